// File: rtl/dec_blk_loader.sv
// Byte-serial loader that assembles a 128-bit ciphertext block and 128-bit key
// and hands the pair downstream over a valid/ready handshake.
module dec_blk_loader #(
  parameter bit KEY_PERSIST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   din,
  input  logic         din_vld,
  input  logic         din_is_key,
  output logic         din_rdy,
  output logic [127:0] blk_out,
  output logic [127:0] key_out,
  output logic         blk_vld,
  input  logic         blk_rdy
);

  // state | meaning
  // LOAD  | accepting data/key bytes until both are complete
  // HOLD  | block and key presented, waiting for blk_rdy
  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [4:0]   data_cnt_q, data_cnt_d;
  logic [4:0]   key_cnt_q, key_cnt_d;
  logic         key_full_q, key_full_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] key_q, key_d;

  logic       in_load;
  logic       data_full;
  logic       accept;
  logic [3:0] data_slot;
  logic [3:0] key_slot;

  assign in_load   = (state_q == ST_LOAD);
  assign data_full = (data_cnt_q == 5'd16);
  // Byte slot counted from the MSB end: first byte lands in [127:120].
  assign data_slot = 4'd15 - data_cnt_q[3:0];
  assign key_slot  = 4'd15 - key_cnt_q[3:0];

  // Readiness depends on the byte type: a full data buffer still takes key bytes.
  assign din_rdy = rst & in_load & (din_is_key | ~data_full);
  assign accept  = din_vld & din_rdy;
  assign blk_vld = rst & (state_q == ST_HOLD);
  assign blk_out = blk_q;
  assign key_out = key_q;

  always_comb begin
    state_d    = state_q;
    data_cnt_d = data_cnt_q;
    key_cnt_d  = key_cnt_q;
    key_full_d = key_full_q;
    blk_d      = blk_q;
    key_d      = key_q;
    if (in_load) begin
      if (accept && !din_is_key) begin
        blk_d[{data_slot, 3'b000} +: 8] = din;
        data_cnt_d = data_cnt_q + 5'd1;
      end
      if (accept && din_is_key) begin
        if (key_full_q) begin
          // A key byte after a complete key starts a fresh key.
          key_d[127:120] = din;
          key_cnt_d      = 5'd1;
          key_full_d     = 1'b0;
        end else begin
          key_d[{key_slot, 3'b000} +: 8] = din;
          key_cnt_d  = key_cnt_q + 5'd1;
          key_full_d = (key_cnt_q == 5'd15);
        end
      end
      if ((data_cnt_d == 5'd16) && key_full_d) begin
        state_d = ST_HOLD;
      end
    end else if (blk_rdy) begin
      state_d    = ST_LOAD;
      data_cnt_d = 5'd0;
      if (!KEY_PERSIST) begin
        key_cnt_d  = 5'd0;
        key_full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_LOAD;
      data_cnt_q <= 5'd0;
      key_cnt_q  <= 5'd0;
      key_full_q <= 1'b0;
      blk_q      <= '0;
      key_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_cnt_q <= data_cnt_d;
      key_cnt_q  <= key_cnt_d;
      key_full_q <= key_full_d;
      blk_q      <= blk_d;
      key_q      <= key_d;
    end
  end

endmodule

// File: tb/tb_dec_blk_loader.sv
// Randomized scoreboard bench for dec_blk_loader: a queue-based byte model predicts
// readiness and completed blocks; a separate monitor checks every handshake.
module tb_dec_blk_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   din = 8'h00;
  logic         din_vld = 1'b0;
  logic         din_is_key = 1'b0;
  logic         din_rdy;
  logic [127:0] blk_out;
  logic [127:0] key_out;
  logic         blk_vld;
  logic         blk_rdy = 1'b0;

  logic         rst0 = 1'b0;
  logic [7:0]   din0 = 8'h00;
  logic         din_vld0 = 1'b0;
  logic         din_is_key0 = 1'b0;
  logic         din_rdy0;
  logic [127:0] blk_out0;
  logic [127:0] key_out0;
  logic         blk_vld0;
  logic         blk_rdy0 = 1'b0;

  always #5 clk = ~clk;

  dec_blk_loader #(.KEY_PERSIST(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_is_key(din_is_key),
    .din_rdy(din_rdy), .blk_out(blk_out), .key_out(key_out), .blk_vld(blk_vld),
    .blk_rdy(blk_rdy)
  );

  dec_blk_loader #(.KEY_PERSIST(1'b0)) dut_np (
    .clk(clk), .rst(rst0), .din(din0), .din_vld(din_vld0), .din_is_key(din_is_key0),
    .din_rdy(din_rdy0), .blk_out(blk_out0), .key_out(key_out0), .blk_vld(blk_vld0),
    .blk_rdy(blk_rdy0)
  );

  typedef struct {
    logic [127:0] blk;
    logic [127:0] key;
  } exp_t;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the bytes received so far in each stream.
  logic [7:0]   m_dq[$];
  logic [7:0]   m_kq[$];
  bit           m_kfull = 1'b0;
  bit           m_hold = 1'b0;
  logic [127:0] m_hblk = '0;
  logic [127:0] m_hkey = '0;
  exp_t         exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [127:0] pack16(input logic [7:0] q[$]);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], q[i]};
    return r;
  endfunction

  function automatic logic [127:0] seq16(input logic [7:0] s, input logic [7:0] st);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], 8'(s + st * 8'(i))};
    return r;
  endfunction

  task automatic cyc(input bit r, input bit v, input bit k, input logic [7:0] b, input bit br);
    bit   exp_rdy;
    exp_t e;
    @(negedge clk);
    rst = r; din_vld = v; din_is_key = k; din = b; blk_rdy = br;
    #1;
    exp_rdy = r && !m_hold && (k || (m_dq.size() < 16));
    check("din_rdy", {127'd0, din_rdy}, {127'd0, exp_rdy});
    check("blk_vld", {127'd0, blk_vld}, {127'd0, r && m_hold});
    if (r && m_hold) begin
      check("hold_blk_stable", blk_out, m_hblk);
      check("hold_key_stable", key_out, m_hkey);
    end
    if (!r) begin
      m_dq.delete(); m_kq.delete(); m_kfull = 1'b0; m_hold = 1'b0; exp_q.delete();
    end else if (m_hold) begin
      if (br) begin
        m_hold = 1'b0;
        m_dq.delete();
      end
    end else if (v && exp_rdy) begin
      if (k) begin
        if (m_kfull) begin
          m_kq.delete();
          m_kfull = 1'b0;
        end
        m_kq.push_back(b);
        if (m_kq.size() == 16) m_kfull = 1'b1;
      end else begin
        m_dq.push_back(b);
      end
      if (m_dq.size() == 16 && m_kfull) begin
        m_hold = 1'b1;
        m_hblk = pack16(m_dq);
        m_hkey = pack16(m_kq);
        e.blk = m_hblk;
        e.key = m_hkey;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h5A, 1'b1);
    check("rst_blk_out", blk_out, '0);
    check("rst_key_out", key_out, '0);
  endtask

  // Monitor: compares every completed handshake against the scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst === 1'b1 && blk_vld === 1'b1 && blk_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL handshake: got unexpected block %h, want none", blk_out);
      end else begin
        e = exp_q.pop_front();
        check("mon_blk_out", blk_out, e.blk);
        check("mon_key_out", key_out, e.key);
      end
    end
  end

  task automatic cyc0(input bit r, input bit v, input bit k, input logic [7:0] b, input bit br);
    @(negedge clk);
    rst0 = r; din_vld0 = v; din_is_key0 = k; din0 = b; blk_rdy0 = br;
    #1;
  endtask

  initial begin
    do_reset();

    // Key of 0x03 then data 0x00..0x0F.
    for (int i = 0; i < 16; i++) cyc(1, 1, 1, 8'h03, 1);
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 8'(i), 1);
    cyc(1, 0, 0, 8'h00, 1);
    check("blk1_const", blk_out, 128'h000102030405060708090a0b0c0d0e0f);
    check("key1_const", key_out, {16{8'h03}});
    cyc(1, 0, 0, 8'h00, 1);

    // Interleaved key 0x10.. and data 0xF0..
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 1, 8'(8'h10 + i), 1);
      cyc(1, 1, 0, 8'(8'hF0 + i), 1);
    end
    cyc(1, 0, 0, 8'h00, 1);
    check("blk2_const", blk_out, seq16(8'hF0, 8'h01));
    check("key2_const", key_out, seq16(8'h10, 8'h01));

    // Persistent key, data only, then backpressure with ignored 0xAA bytes.
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 8'(8'h20 + i), 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, i[0], 8'hAA, 0);
    check("persist_key", key_out, seq16(8'h10, 8'h01));
    check("blk3_const", blk_out, seq16(8'h20, 8'h01));
    cyc(1, 0, 0, 8'h00, 1);
    cyc(1, 0, 0, 8'h00, 0);

    // Restart the key, then overfill the data stream.
    cyc(1, 1, 1, 8'h55, 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 8'(8'h80 + i), 0);
    check("overfill_blk", blk_out, seq16(8'h80, 8'h01));
    for (int i = 0; i < 15; i++) cyc(1, 1, 1, 8'(8'h56 + i), 0);
    cyc(1, 0, 0, 8'h00, 1);
    cyc(1, 0, 0, 8'h00, 1);

    // Reset mid-load, then a fresh full block.
    for (int i = 0; i < 9; i++) cyc(1, 1, 0, 8'(8'hE0 + i), 0);
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 1, 1, 8'(8'hC0 + i), 1);
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 8'(8'hD0 + i), 1);
    cyc(1, 0, 0, 8'h00, 1);
    cyc(1, 0, 0, 8'h00, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 300) != 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
          8'($urandom), ($urandom % 3) != 0);
    end
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'h00, 1);
    check("scoreboard_drained", 128'(exp_q.size()), '0);

    // Non-persistent key instance.
    cyc0(0, 0, 0, 8'h00, 0);
    cyc0(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) cyc0(1, 1, 1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 16; i++) cyc0(1, 1, 0, 8'(8'h50 + i), 0);
    cyc0(1, 0, 0, 8'h00, 1);
    check("np_vld1", {127'd0, blk_vld0}, 128'd1);
    check("np_blk1", blk_out0, seq16(8'h50, 8'h01));
    check("np_key1", key_out0, seq16(8'h40, 8'h01));
    cyc0(1, 0, 0, 8'h00, 1);
    check("np_vld_drop", {127'd0, blk_vld0}, 128'd0);
    for (int i = 0; i < 16; i++) cyc0(1, 1, 0, 8'(8'h60 + i), 1);
    for (int i = 0; i < 4; i++) begin
      cyc0(1, 1, 0, 8'h77, 1);
      check("np_no_vld_wo_key", {127'd0, blk_vld0}, 128'd0);
      check("np_data_refused", {127'd0, din_rdy0}, 128'd0);
    end
    for (int i = 0; i < 16; i++) cyc0(1, 1, 1, 8'(8'h70 + i), 0);
    cyc0(1, 0, 0, 8'h00, 0);
    check("np_vld2", {127'd0, blk_vld0}, 128'd1);
    check("np_blk2", blk_out0, seq16(8'h60, 8'h01));
    check("np_key2", key_out0, seq16(8'h70, 8'h01));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dec_blk_loader.md
Name: dec_blk_loader

Overview:
- Byte-serial input stage directly upstream of the decryption Caesar layer.
- Assembles 16 ciphertext bytes and 16 key bytes from an 8-bit stream into a 128-bit block and a 128-bit key.
- Presents the pair with a valid/ready handshake, so the Caesar subtraction and the inverse AES rounds see a stable block and key.
- The key can persist across blocks, so one key load serves many ciphertext blocks.

Parameters:
- KEY_PERSIST, 1: 1 = key survives a block transfer; 0 = key must be reloaded for every block.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the clk rising edge.
- din  input  8  input byte.
- din_vld  input  1  din valid.
- din_is_key  input  1  1 = din is a key byte; 0 = din is a ciphertext byte.
- din_rdy  output  1  loader can accept a byte this cycle.
- blk_out  output  128  assembled ciphertext block; first byte received is in [127:120].
- key_out  output  128  assembled key; first key byte is in [127:120] (the Caesar shift byte).
- blk_vld  output  1  blk_out and key_out are complete and stable.
- blk_rdy  input  1  downstream accepts the block.

Behaviour:
- Reset (rst=0 at a clk edge) forces:
  - blk_out=0, key_out=0, blk_vld=0, din_rdy=0 during reset.
  - data_cnt=0, key_cnt=0, key_full=0, state=LOAD.
  - din_rdy=1 from the first cycle after reset deasserts.
- Reset mid-load or mid-hold discards all partial and complete data. There is no transfer in the reset cycle.
- States: LOAD and HOLD.
- LOAD:
  - din_rdy=1. A byte is accepted when din_vld=1.
  - Data byte (din_is_key=0), accepted only if data_full=0:
    - written to blk_out[127-8*data_cnt -: 8], then data_cnt increments.
    - data_cnt reaching 16 sets data_full.
    - A data byte arriving while data_full=1 is also blocked: din_rdy=0 for data bytes in that case. din_rdy is therefore qualified by din_is_key.
  - Key byte (din_is_key=1):
    - If key_full=1: clear key_full, write the byte to key_out[127:120], set key_cnt=1 (start of a new key).
    - Otherwise: write the byte to key_out[127-8*key_cnt -: 8], then key_cnt increments; key_cnt reaching 16 sets key_full.
  - Counters are 5-bit, range 0..16, and never wrap.
- LOAD -> HOLD:
  - Taken at the clk edge after the cycle in which data_full and key_full are both 1.
  - blk_vld=1 in HOLD, so blk_vld rises exactly 1 cycle after the final byte is accepted.
  - If both are already full, the transition happens on the next edge.
- HOLD:
  - din_rdy=0. din is ignored even if din_vld=1.
  - blk_out and key_out are held constant.
  - blk_vld stays 1 until blk_rdy=1 is sampled.
- HOLD -> LOAD on blk_vld & blk_rdy:
  - Next cycle: blk_vld=0, din_rdy=1, data_cnt=0, data_full=0.
  - blk_out keeps its old value until overwritten.
  - KEY_PERSIST=1: key_full and key_out are retained, so the next block needs only 16 data bytes.
  - KEY_PERSIST=0: key_cnt=0 and key_full=0.
- blk_rdy=1 while blk_vld=0 has no effect.
- Throughput:
  - With a persistent key: 16 data cycles + 1 HOLD cycle (blk_rdy held at 1), giving 17 clk per block.
  - First block: 32 + 1 cycles minimum.
- Data and key bytes may be interleaved in any order; only the order within each stream matters.

Test Plan:
- Reset then 16 key bytes 0x03, then data 0x00..0x0F, with blk_rdy=1:
  - blk_vld rises 1 cycle after byte 0x0F.
  - blk_out=0x000102...0F, key_out=0x0303...03.
  - blk_vld falls the next cycle.
- Interleave key and data bytes (K0,D0,K1,D1,...), key 0x10..0x1F, data 0xF0..0xFF:
  - key_out=0x101112...1F, blk_out=0xF0F1...FF.
- Backpressure: blk_rdy=0 for 5 cycles after blk_vld:
  - blk_vld, blk_out and key_out stay stable.
  - din_rdy=0, and din_vld with 0xAA pulses has no effect.
  - blk_rdy=1 completes the transfer in 1 cycle.
- KEY_PERSIST=1, second block of data 0x20..0x2F with no key bytes:
  - blk_vld rises and key_out is unchanged.
  - With KEY_PERSIST=0, blk_vld stays 0 until 16 new key bytes arrive.
- Send 20 data bytes with no key:
  - bytes 17..20 are refused (din_rdy=0 with din_is_key=0).
  - blk_out holds the first 16 bytes.
  - A key byte is still accepted.
- Assert rst=0 after 9 data bytes:
  - All outputs and counters clear.
  - A fresh full load produces the correct block with no stale bytes.
